// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: tick marks the last clk of each serial bit while enabled.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!enable || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter; define UART_TX_PARITY_EN to add an even parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_t          state, state_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic [2:0]           idx, idx_nx;
    logic                 tx_nx;
    logic                 armed;
    logic                 tick;
    logic                 accept;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state != IDLE),
        .tick   (tick)
    );

    // Holds ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    assign tx_ready = armed && (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign accept   = tx_valid && tx_ready;

`ifdef UART_TX_PARITY_EN
    logic par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      par <= 1'b0;
        else if (accept) par <= ^tx_data;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            idx   <= idx_nx;
            tx    <= tx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = START;
            START: if (tick) state_nx = DATA;
            DATA:
                if (tick && idx == LAST_DATA)
`ifdef UART_TX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) state_nx = STOP;
`endif
            STOP:  if (tick && idx == LAST_STOP) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // idx counts data bits, then restarts at 0 to count stop bits.
    always_comb begin
        shreg_nx = shreg;
        idx_nx   = idx;
        case (state)
            IDLE:
                if (accept) begin
                    shreg_nx = tx_data;
                    idx_nx   = '0;
                end
            DATA:
                if (tick) begin
                    shreg_nx = shreg >> 1;
                    idx_nx   = idx + 1'b1;
                end
            STOP:
                if (tick)
                    idx_nx = (idx == LAST_STOP) ? 3'd0 : idx + 1'b1;
            default: ;
        endcase
    end

    // tx is registered from the upcoming state so the line never glitches.
    always_comb begin
        tx_nx = 1'b1;
        case (state_nx)
            START:  tx_nx = 1'b0;
            DATA:   tx_nx = shreg_nx[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_nx = par;
`endif
            default: tx_nx = 1'b1;
        endcase
    end

    assign tx_done = (state == STOP) && tick && (idx == LAST_STOP);

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: one instance with 1 stop bit, one with 2, CLKS_PER_BIT=4.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data  [2];
    logic       valid [2];
    logic       ready [2];
    logic       tx_w  [2];
    logic       busy  [2];
    logic       done  [2];
    int         cyc = 0;
    int         nchk = 0;
    int         nfail = 0;
    bit         exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx(tx_w[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx(tx_w[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int stop_bits(input int w);
        return (w == 0) ? 1 : 2;
    endfunction

    // Reference line sequence, one entry per bit time.
    task automatic build(input logic [7:0] b, input int sb);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (P == 1) exp_q.push_back(^b);
        for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
    endtask

    // Checks the line cycle by cycle; max_cyc < 0 means the whole frame.
    task automatic play(input int w, input bit scramble, input int max_cyc);
        int n = exp_q.size();
        int seen = 0;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (max_cyc >= 0 && seen >= max_cyc) return;
                @(negedge clk);
                seen++;
                if (scramble) data[w] = 8'($urandom);
                chk("tx_bit",  tx_w[w], exp_q[k]);
                chk("busy",    busy[w], 1);
                chk("ready",   ready[w], 0);
                chk("done",    done[w], (k == n - 1) && (c == CPB - 1));
            end
        end
    endtask

    task automatic idle_chk(input int w);
        @(negedge clk);
        chk("idle_tx",    tx_w[w], 1);
        chk("idle_ready", ready[w], 1);
        chk("idle_busy",  busy[w], 0);
        chk("idle_done",  done[w], 0);
    endtask

    task automatic send(input int w, input logic [7:0] b, input bit scramble, input int max_cyc);
        @(negedge clk);
        chk("ready_pre", ready[w], 1);
        data[w]  = b;
        valid[w] = 1'b1;
        build(b, stop_bits(w));
        @(posedge clk);
        #1 valid[w] = 1'b0;
        play(w, scramble, max_cyc);
    endtask

    initial begin
        int t0, t1;
        logic [7:0] b;
        rst_n = 1'b0;
        for (int w = 0; w < 2; w++) begin
            data[w]  = '0;
            valid[w] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk("rst_tx",    tx_w[w], 1);
            chk("rst_ready", ready[w], 0);
            chk("rst_busy",  busy[w], 0);
            chk("rst_done",  done[w], 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) chk("ready_after_rst", ready[w], 1);

        // Directed bytes, including the parity reference patterns.
        send(0, 8'hA5, 1'b0, -1);
        idle_chk(0);
        send(0, 8'h07, 1'b0, -1);
        idle_chk(0);

        // Back-to-back frames with valid held high.
        @(negedge clk);
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        build(8'h00, 1);
        @(posedge clk);
        #1 t0 = cyc;
        data[0] = 8'hFF;
        play(0, 1'b0, -1);
        idle_chk(0);
        build(8'hFF, 1);
        @(posedge clk);
        #1 t1 = cyc;
        valid[0] = 1'b0;
        chk("frame_period", t1 - t0, (1 + 8 + P + 1) * CPB + 1);
        play(0, 1'b0, -1);
        idle_chk(0);

        // Random bytes with mid-frame data noise and random idle gaps.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(w, 8'($urandom), 1'b1, -1);
                idle_chk(w);
            end
        end

        // Reset mid-frame, inside the fourth bit time (data bit 2 forced low).
        b = 8'($urandom) & 8'hFB;
        send(0, b, 1'b0, 3 * CPB + 2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx",    tx_w[0], 1);
        chk("abort_busy",  busy[0], 0);
        chk("abort_ready", ready[0], 0);
        chk("abort_done",  done[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rearm_ready", ready[0], 1);
        chk("rearm_busy",  busy[0], 0);
        for (int i = 0; i < 12 * CPB; i++) begin
            @(negedge clk);
            chk("post_abort_tx",   tx_w[0], 1);
            chk("post_abort_done", done[0], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range >= 2.
REQ-002 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_data  input  8  byte to send; sampled only on the accept cycle.
REQ-006 SHALL have port tx_valid  input  1  tx_data holds a byte to send.
REQ-007 SHALL have port tx_ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port tx_busy  output  1  a frame is in progress.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at end of frame.

Function
REQ-011 SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL drive tx_ready=1 only in IDLE; tx_busy SHALL equal NOT tx_ready.
REQ-013 SHALL accept a byte on any cycle with tx_valid=1 and tx_ready=1, latch tx_data into a shift register and move to START.
REQ-014 SHALL ignore tx_data and tx_valid on every non-accept cycle; a byte held during a frame is not lost, only deferred.
REQ-015 SHALL drive tx=1 in IDLE, tx=0 for START, data bits LSB first in DATA, tx=1 in STOP.
REQ-016 SHALL begin the start bit on the cycle after acceptance; every bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-017 SHALL count bit time with a counter of width $clog2(CLKS_PER_BIT), reset to 0 at each bit boundary, no wrap beyond CLKS_PER_BIT-1.
REQ-018 SHALL count 8 data bits with a 3-bit index; DATA exits after index 7 completes.
REQ-019 SHALL hold STOP for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-020 SHALL pulse tx_done on the last cycle of the last stop bit only.
REQ-021 SHALL, with tx_valid held high continuously, accept the next byte on the first IDLE cycle, giving frame period (1+8+P+STOP_BITS)*CLKS_PER_BIT+1 cycles, P = 1 if parity compiled in, else 0.
REQ-022 SHALL drive tx from a register (glitch-free, no combinational path from inputs to tx).

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, tx=1, tx_ready=0, tx_busy=0, tx_done=0, counters 0, shift register 0.
REQ-024 SHALL on reset mid-frame abort immediately (tx high asynchronously); the aborted byte is dropped, not resent.
REQ-025 SHALL assert tx_ready on the first clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL with macro UART_TX_PARITY_EN defined insert PARITY state after DATA, one bit time carrying even parity (XOR of the 8 data bits).
REQ-027 SHALL without UART_TX_PARITY_EN go directly DATA -> STOP; PARITY state and parity logic absent.

Structure
REQ-028 SHALL take the state enumeration and the constant DATA_BITS=8 from shared package uart_pkg, also used by the receive side.
REQ-029 SHALL place bit-time counting in sub-module uart_baud_tick (clk, rst_n, enable, tick output at count CLKS_PER_BIT-1); FSM advances on tick.

Verification
REQ-030 SHALL check CLKS_PER_BIT=4, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, start bit on cycle after accept, tx_done pulse on last stop cycle.
REQ-031 SHALL check tx_valid held with 0x00 then 0xFF -> second start bit exactly 41 cycles after first (parity off), one idle-high cycle between frames.
REQ-032 SHALL check rst_n low during bit 3 of a frame -> tx=1 same cycle, tx_busy=0, tx_ready=1 one edge after release, no remaining bits emitted.
REQ-033 SHALL check with UART_TX_PARITY_EN, 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame 11 bit times.
REQ-034 SHALL check STOP_BITS=2, CLKS_PER_BIT=4 -> stop high 8 cycles, tx_done on 8th, tx_data changes mid-frame have no effect on tx.
